// File: rtl/r_burst_arbiter_pkg.sv
// Shared definitions for the R-channel burst arbiter: FSM states, payload layout
// and the modulo helper used by the round-robin search.
package r_burst_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int R_PAYLOAD_W = 77;
  localparam int RLAST_BIT   = 0;

  // Requester index reached by stepping 'step' slots past 'base', wrapping at 'n'.
  function automatic int wrap_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/r_burst_arbiter_skid.sv
// Two-entry FIFO skid buffer: registered full/empty flags, head always presented.
module r_skid_buffer #(
  parameter int DATA_W = 77
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // Ready comes only from the registered count, so a pop never re-opens the input the same cycle.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/r_burst_arbiter.sv
// Burst-locked round-robin arbiter for AXI4 R beats; a grant is held until the
// RLAST beat is accepted, and beats leave through a 2-entry skid buffer.
module r_burst_arbiter
  import r_burst_arbiter_pkg::*;
#(
  parameter int NUM_SLV  = 4,
  parameter int DATA_W   = R_PAYLOAD_W,
  parameter int LAST_BIT = RLAST_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SLV*DATA_W-1:0] s_data,
  input  logic [NUM_SLV-1:0]        s_valid,
  output logic [NUM_SLV-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [NUM_SLV-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_SLV);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  idx;
  logic              found;
  logic [DATA_W-1:0] owner_data;
  logic              owner_valid;
  logic              owner_last;
  logic              skid_in_ready;
  logic              accept;

  // First requesting slot after the last burst owner, wrapping to slot 0.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_SLV; i++) begin
      idx = IDX_W'(wrap_index(int'(ptr), i, NUM_SLV));
      if (!found && s_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (state == ST_LOCKED) begin
      s_ready[owner] = skid_in_ready;
    end
  end

  assign owner_data  = s_data[owner*DATA_W +: DATA_W];
  assign owner_valid = (state == ST_LOCKED) & s_valid[owner];
  assign owner_last  = owner_data[LAST_BIT];
  assign accept      = owner_valid & skid_in_ready;
  assign busy        = (state == ST_LOCKED) | m_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= IDX_W'(NUM_SLV - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_valid) begin
            state <= ST_LOCKED;
            owner <= winner;
            grant <= NUM_SLV'(1) << winner;
          end
        end
        ST_LOCKED: begin
          if (accept && owner_last) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= owner;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  r_skid_buffer #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (owner_data),
    .in_valid (owner_valid),
    .in_ready (skid_in_ready),
    .out_data (m_data),
    .out_valid(m_valid),
    .out_ready(m_ready)
  );

endmodule

// File: tb/tb_r_burst_arbiter.sv
// Randomized bench for r_burst_arbiter against a queue-based reference model of
// burst ownership, round-robin order and the two-slot output buffer.
module tb_r_burst_arbiter;

  localparam int N = 4;
  localparam int W = 77;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid;
  logic           m_ready;
  logic [N-1:0]   grant;
  logic           busy;

  r_burst_arbiter #(.NUM_SLV(N), .DATA_W(W), .LAST_BIT(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .grant  (grant),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int num_vectors = 0;
  int num_miscompares = 0;

  // Reference model: owner (-1 = no burst), last winner, buffered beats.
  int           owner;
  int           ptr;
  logic [W-1:0] q[$];
  bit           model_known = 0;

  // Requester-side burst generators.
  int           beats_left[N];
  int           beat_idx[N];
  logic [W-1:0] cur[N];

  int           vprob = 100;
  int           rprob = 100;
  logic [N-1:0] mask = '1;
  int           fixed_len = 0;
  bit           directed = 0;
  bit           drain = 0;

  bit           record_grants = 0;
  bit           record_pops = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] grant_log[$];
  logic [W-1:0] pop_log[$];

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic make_beat(input int i);
    if (beats_left[i] == 0) begin
      beats_left[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
      beat_idx[i]   = 0;
    end
    if (directed) cur[i] = W'((10 + beat_idx[i]) << 1);
    else          cur[i] = W'({$urandom(), $urandom(), $urandom()});
    cur[i][0] = (beats_left[i] == 1);
  endtask

  task automatic applyStimulus(input bit do_reset);
    logic [N-1:0] exp_ready;
    bit           accept;
    bit           pop;
    int           acc_idx;

    @(negedge clk);
    if (model_known) begin
      checkOutput("m_valid", W'(m_valid), W'(q.size() > 0));
      checkOutput("grant", W'(grant), (owner >= 0) ? W'(1) << owner : W'(0));
      checkOutput("busy", W'(busy), W'((owner >= 0) || (q.size() > 0)));
      if (q.size() > 0) checkOutput("m_data", m_data, q[0]);
    end
    if (record_grants && grant != 0 && prev_grant == 0) grant_log.push_back(grant);
    prev_grant = grant;

    reset = do_reset;
    for (int i = 0; i < N; i++) begin
      if (drain) s_valid[i] = (i == owner);
      else       s_valid[i] = mask[i] && ($urandom_range(0, 99) < vprob);
      s_data[i*W +: W] = cur[i];
    end
    m_ready = ($urandom_range(0, 99) < rprob);
    #1;

    exp_ready = '0;
    accept = 0;
    pop = 0;
    acc_idx = owner;
    if (model_known) begin
      if (owner >= 0 && q.size() < 2) exp_ready[owner] = 1'b1;
      checkOutput("s_ready", W'(s_ready), W'(exp_ready));
      accept = (owner >= 0) && s_valid[owner] && (q.size() < 2);
      pop    = (q.size() > 0) && m_ready;
    end
    if (record_pops && m_valid && m_ready) pop_log.push_back(m_data);

    if (pop) void'(q.pop_front());
    if (do_reset) begin
      owner = -1;
      ptr   = N - 1;
      q.delete();
    end else begin
      if (accept) q.push_back(cur[owner]);
      if (owner < 0) begin
        if (|s_valid) begin
          for (int k = 1; k <= N; k++) begin
            if (owner < 0 && s_valid[(ptr + k) % N]) owner = (ptr + k) % N;
          end
        end
      end else if (accept && cur[owner][0]) begin
        ptr   = owner;
        owner = -1;
      end
    end
    if (accept) begin
      beats_left[acc_idx]--;
      beat_idx[acc_idx]++;
      make_beat(acc_idx);
    end
    if (do_reset) model_known = 1;
  endtask

  initial begin
    logic [N-1:0] exp_grants[5];
    logic [7:0]   exp_dir[4];
    int           guard;

    exp_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dir    = '{8'h14, 8'h16, 8'h18, 8'h1B};
    reset   = 1'b1;
    s_valid = '0;
    s_data  = '0;
    m_ready = 1'b0;
    owner   = -1;
    ptr     = N - 1;
    fixed_len = 2;
    for (int i = 0; i < N; i++) begin
      beats_left[i] = 0;
      make_beat(i);
    end

    // Reset with every requester asserting valid, then round-robin over 2-beat bursts.
    applyStimulus(1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("reset_m_data", m_data, W'(0));
    record_grants = 1;
    for (int c = 0; c < 20; c++) applyStimulus(0);
    record_grants = 0;
    checkOutput("rr_grant_count", W'(grant_log.size() >= 5), W'(1));
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      checkOutput($sformatf("rr_grant_%0d", k), W'(grant_log[k]), W'(exp_grants[k]));

    // Let the current burst finish so slot 2 starts clean.
    drain = 1;
    guard = 0;
    while ((owner >= 0 || q.size() > 0) && guard < 50) begin
      applyStimulus(0);
      guard++;
    end
    drain = 0;
    checkOutput("drain_timeout", W'(guard < 50), W'(1));

    mask = 4'b0100;
    fixed_len = 4;
    directed = 1;
    beats_left[2] = 0;
    make_beat(2);
    record_pops = 1;
    for (int c = 0; c < 8; c++) applyStimulus(0);
    record_pops = 0;
    directed = 0;
    checkOutput("dir_count", W'(pop_log.size() >= 4), W'(1));
    for (int k = 0; k < 4 && k < pop_log.size(); k++)
      checkOutput($sformatf("dir_beat_%0d", k), W'(pop_log[k][7:0]), W'(exp_dir[k]));

    // Backpressure, then release.
    mask = '1;
    fixed_len = 0;
    rprob = 0;
    for (int c = 0; c < 6; c++) applyStimulus(0);
    rprob = 100;
    for (int c = 0; c < 20; c++) applyStimulus(0);

    // Random traffic with valid gaps and random master stalls.
    vprob = 60;
    rprob = 60;
    for (int c = 0; c < 600; c++) applyStimulus(0);

    // Fill the skid under a locked owner, then reset mid-burst.
    vprob = 100;
    rprob = 0;
    guard = 0;
    while (!(owner >= 0 && q.size() == 2) && guard < 20) begin
      applyStimulus(0);
      guard++;
    end
    checkOutput("skid_fill_timeout", W'(guard < 20), W'(1));
    applyStimulus(1);
    rprob = 100;
    grant_log.delete();
    prev_grant = '0;
    record_grants = 1;
    for (int c = 0; c < 4; c++) applyStimulus(0);
    record_grants = 0;
    checkOutput("post_reset_grant_seen", W'(grant_log.size() >= 1), W'(1));
    if (grant_log.size() >= 1)
      checkOutput("post_reset_grant", W'(grant_log[0]), W'(4'b0001));

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
